// File: rtl/cpu_bus_master_pkg.sv
// cpu_bus_master_pkg: shared FSM state codes and width helpers for the bus master.
package cpu_bus_master_pkg;
  typedef enum logic [2:0] {
    io_idle        = 3'd0,
    io_read_begin  = 3'd1,
    io_read_wait   = 3'd2,
    io_write_begin = 3'd3,
    io_write_wait  = 3'd4,
    io_done        = 3'd5
  } io_state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int t);
    return t > 0 ? $clog2(t + 1) : 1;
  endfunction
endpackage

// File: rtl/cpu_bus_master_rr_arbiter.sv
// rr_arbiter: fixed-priority or round-robin pick of one requester, one-hot grant plus index.
module rr_arbiter
  import cpu_bus_master_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx
);
  logic             found;
  logic [IDX_W-1:0] c;
  // Scan from the pointer in round-robin mode, from channel 0 otherwise.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      c = mode ? IDX_W'((int'(ptr) + i) % N_REQ) : IDX_W'(i);
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end
endmodule

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: arbitrates CPU requesters onto a single begin/wait bus with timeout.
module cpu_bus_master
  import cpu_bus_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int N_REQ   = 3,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        req_error,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [DATA_W-1:0]       bus_wdata,
  output logic                    bus_read,
  output logic                    bus_write,
  input  logic [DATA_W-1:0]       bus_rdata,
  input  logic                    bus_ready,
  output logic [2:0]              io_state
);
  localparam int IDX_W = idx_w(N_REQ);
  localparam int CNT_W = cnt_w(TIMEOUT);
  io_state_t        state, next;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] gidx, g, rr_ptr;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q;
  logic             sel_write, err, tmo, waiting, accept;
  logic [CNT_W-1:0] cnt;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req  (req_valid),
    .mode (RR_MODE != 0),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (gidx)
  );
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end
  assign sel_write = |(req_write & grant);
  assign waiting   = state == io_read_wait || state == io_write_wait;
  assign accept    = state == io_idle && |req_valid;
  assign tmo       = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT);
  always_ff @(posedge clk) state <= reset ? io_idle : next;
  always_comb begin
    next = io_idle;
    case (state)
      io_idle:        next = !accept ? io_idle : sel_write ? io_write_begin : io_read_begin;
      io_read_begin:  next = io_read_wait;
      io_write_begin: next = io_write_wait;
      io_read_wait:   next = bus_ready || tmo ? io_done : io_read_wait;
      io_write_wait:  next = bus_ready || tmo ? io_done : io_write_wait;
      io_done:        next = io_idle;
      default:        next = io_idle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      g       <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      err     <= 1'b0;
      rdata   <= '0;
      rr_ptr  <= '0;
    end else begin
      if (accept) begin
        g       <= gidx;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == io_read_begin || state == io_write_begin) cnt <= '0;
      else if (waiting && !bus_ready && !tmo) cnt <= cnt + 1'b1;
      // Ready takes precedence over a timeout landing on the same cycle.
      if (waiting && !bus_ready && tmo) err <= 1'b1;
      else if (state == io_done) err <= 1'b0;
      if (state == io_read_wait && bus_ready) rdata <= bus_rdata;
      if (state == io_done && RR_MODE != 0) rr_ptr <= g == IDX_W'(N_REQ - 1) ? '0 : g + 1'b1;
    end
  end
  always_comb begin
    req_done  = '0;
    req_error = '0;
    if (state == io_done) begin
      req_done[g]  = 1'b1;
      req_error[g] = err;
    end
  end
  assign bus_read  = state == io_read_begin;
  assign bus_write = state == io_write_begin;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign io_state  = state;
endmodule

// File: tb/tb_cpu_bus_master.sv
// tb_cpu_bus_master: directed vector bench for cpu_bus_master in fixed and round-robin modes.
module tb_cpu_bus_master;
  localparam int AW = 32, DW = 32, N = 3, TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [N-1:0]    req_valid = '0, req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   bus_rdata = '0;
  logic            bus_ready = 1'b0;
  logic [N-1:0]    a_done, a_err, b_done, b_err;
  logic [DW-1:0]   a_rdata, b_rdata, a_wdata, b_wdata;
  logic [AW-1:0]   a_addr, b_addr;
  logic            a_rd, a_wr, b_rd, b_wr;
  logic [2:0]      a_state, b_state;
  int checks = 0, errors = 0;

  cpu_bus_master #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(N), .RR_MODE(0), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(a_done), .req_error(a_err),
    .rdata(a_rdata), .bus_addr(a_addr), .bus_wdata(a_wdata), .bus_read(a_rd),
    .bus_write(a_wr), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .io_state(a_state));
  cpu_bus_master #(.ADDR_W(AW), .DATA_W(DW), .N_REQ(N), .RR_MODE(1), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(b_done), .req_error(b_err),
    .rdata(b_rdata), .bus_addr(b_addr), .bus_wdata(b_wdata), .bus_read(b_rd),
    .bus_write(b_wr), .bus_rdata(bus_rdata), .bus_ready(bus_ready), .io_state(b_state));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] oh);
    int r = -1;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic        wr;
    int          ch;
    logic [31:0] addr, wdata, brdata;
    int          rdy;
    logic [2:0]  exp_done, exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vecs[7];

  // rdy = cycles after the strobe at which bus_ready rises; lat = strobe to done pulse.
  task automatic run_vec(input vec_t v, input int k);
    int s = -1, d = -1, strobes = 0;
    logic stable = 1'b1, swr = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_valid[v.ch] = 1'b1;
    req_write[v.ch] = v.wr;
    req_addr[v.ch*AW +: AW] = v.addr;
    req_wdata[v.ch*DW +: DW] = v.wdata;
    bus_rdata = v.brdata;
    bus_ready = 1'b0;
    for (int t = 0; t < 20 && d < 0; t++) begin
      @(negedge clk);
      if (a_rd | a_wr) begin
        strobes++;
        if (s < 0) begin s = t; swr = a_wr; end
      end
      if (s >= 0 && (a_addr !== v.addr || a_wdata !== v.wdata)) stable = 1'b0;
      if (a_done != 0) begin
        d = t;
        chk($sformatf("v%0d done", k), a_done, v.exp_done);
        chk($sformatf("v%0d error", k), a_err, v.exp_err);
        chk($sformatf("v%0d rr done", k), b_done, v.exp_done);
        chk($sformatf("v%0d rdata", k), a_rdata, v.exp_rdata);
        req_valid = '0;
      end
      if (s >= 0) bus_ready = (t - s) >= v.rdy;
    end
    bus_ready = 1'b0;
    chk($sformatf("v%0d done seen", k), d >= 0, 1);
    chk($sformatf("v%0d latency", k), d - s, v.exp_lat);
    chk($sformatf("v%0d strobe count", k), strobes, 1);
    chk($sformatf("v%0d strobe kind", k), swr, v.wr);
    chk($sformatf("v%0d addr/wdata stable", k), stable, 1);
    @(negedge clk);
    chk($sformatf("v%0d back to idle", k), a_state, 0);
    chk($sformatf("v%0d done one cycle", k), a_done, 0);
  endtask

  initial begin
    int na = 0, nb = 0, s = -1;
    logic seen;
    int ord_a[4], ord_b[4], tb_t[4];
    int exp_b[4] = '{0, 1, 2, 0};
    vecs[0] = '{1'b0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 3'b001, 3'b000, 32'hDEADBEEF, 3};
    vecs[1] = '{1'b1, 2, 32'h200, 32'h12345678, 32'hAAAAAAAA, 1, 3'b100, 3'b000, 32'hDEADBEEF, 2};
    vecs[2] = '{1'b0, 1, 32'h300, 32'h0, 32'h11111111, 99, 3'b010, 3'b010, 32'hDEADBEEF, 6};
    vecs[3] = '{1'b0, 1, 32'h304, 32'h0, 32'h0BADF00D, 5, 3'b010, 3'b000, 32'h0BADF00D, 6};
    vecs[4] = '{1'b1, 0, 32'h400, 32'hCAFEF00D, 32'h22222222, 6, 3'b001, 3'b001, 32'h0BADF00D, 6};
    vecs[5] = '{1'b0, 2, 32'h500, 32'h0, 32'h55AA55AA, 1, 3'b100, 3'b000, 32'h55AA55AA, 2};
    vecs[6] = '{1'b1, 1, 32'h600, 32'h87654321, 32'h33333333, 0, 3'b010, 3'b000, 32'h55AA55AA, 2};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset state", a_state, 0);
    chk("reset strobes", {a_rd, a_wr}, 0);
    chk("reset bus_addr", a_addr, 0);
    chk("reset bus_wdata", a_wdata, 0);
    chk("reset rdata", a_rdata, 0);
    chk("reset done/error", {a_done, a_err}, 0);
    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Reset while a read is waiting abandons it silently.
    req_valid = 3'b001;
    req_write = '0;
    for (int t = 0; t < 10 && s < 0; t++) begin
      @(negedge clk);
      if (a_rd) s = t;
    end
    chk("abort strobe seen", s >= 0, 1);
    @(negedge clk);
    chk("abort in read_wait", a_state, 2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort state", a_state, 0);
    chk("abort outputs", {a_rd, a_wr, a_done, a_err}, 0);
    chk("abort bus_addr", a_addr, 0);
    chk("abort rdata", a_rdata, 0);
    reset = 1'b0;
    req_valid = '0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_done != 0 || a_err != 0) seen = 1'b1;
    end
    chk("abort no done", seen, 0);

    // Continuous requests on all channels: fixed vs round-robin completion order.
    req_valid = 3'b111;
    req_write = '0;
    bus_ready = 1'b1;
    for (int t = 0; t < 60 && (na < 4 || nb < 4); t++) begin
      @(negedge clk);
      if (a_done != 0 && na < 4) begin ord_a[na] = oh2i(a_done); na++; end
      if (b_done != 0 && nb < 4) begin ord_b[nb] = oh2i(b_done); tb_t[nb] = t; nb++; end
    end
    req_valid = '0;
    bus_ready = 1'b0;
    chk("order completions", {na[7:0], nb[7:0]}, {8'd4, 8'd4});
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fixed order %0d", i), ord_a[i], 0);
      chk($sformatf("rr order %0d", i), ord_b[i], exp_b[i]);
    end
    chk("back-to-back spacing", tb_t[1] - tb_t[0], 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
